// File: rtl/write_ptr_counter.sv
// -----------------------------------------------------------------------------
// write_ptr_counter
// Write-side pointer generator for an asynchronous FIFO. Keeps a binary write
// pointer with an extra wrap bit, a registered Gray copy for the read domain,
// and full / almost-full flags computed against the synchronised read pointer.
// It also reports write acknowledge and overflow pulses.
//
// Parameters
//   a_length   address width; FIFO depth = 2**a_length, pointers a_length+1 bits
//   af_margin  almost_full_out asserts when free slots <= af_margin
//
// Ports
//   b_ctr_clk            write-domain clock, rising edge
//   b_ctr_reset          synchronous active-high reset
//   b_ctr_enable_in      write request for this cycle
//   b_ctr_clear          synchronous soft clear (lower priority than reset)
//   rd_gray_ptr_sync_in  read pointer, Gray coded, already in b_ctr_clk domain
//   b_count_ptr          registered binary write pointer (MSB = wrap bit)
//   g_count_ptr          registered Gray write pointer
//   wr_addr              RAM write address (low bits of b_count_ptr)
//   wr_en_out            combinational RAM write strobe
//   full_out             registered full flag
//   almost_full_out      registered almost-full flag
//   wr_ack_out           one-cycle pulse per accepted write
//   overflow_out         one-cycle pulse per rejected write
// -----------------------------------------------------------------------------
module write_ptr_counter #(
   parameter int unsigned a_length  = 3,
   parameter int unsigned af_margin = 1
) (
   input  logic                b_ctr_clk,
   input  logic                b_ctr_reset,
   input  logic                b_ctr_enable_in,
   input  logic                b_ctr_clear,
   input  logic [a_length:0]   rd_gray_ptr_sync_in,
   output logic [a_length:0]   b_count_ptr,
   output logic [a_length:0]   g_count_ptr,
   output logic [a_length-1:0] wr_addr,
   output logic                wr_en_out,
   output logic                full_out,
   output logic                almost_full_out,
   output logic                wr_ack_out,
   output logic                overflow_out
);

   localparam int unsigned PTR_W = a_length + 1;
   localparam int unsigned DEPTH = 2 ** a_length;

   logic [PTR_W-1:0] rd_bin;
   logic [PTR_W-1:0] next_bin;
   logic [PTR_W-1:0] next_gray;
   logic [PTR_W-1:0] used_nxt;
   logic [PTR_W-1:0] free_nxt;
   logic             full_nxt;
   logic             almost_full_nxt;

   // RAM strobe and address are valid in the request cycle
   assign wr_en_out = b_ctr_enable_in & ~full_out;
   assign wr_addr   = b_count_ptr[a_length-1:0];

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      rd_bin = '0;
      for (int i = 0; i < int'(PTR_W); i++) begin
         rd_bin[i] = ^(rd_gray_ptr_sync_in >> i);
      end
   end

   // Next pointer, its Gray image, and flags against the current read pointer
   always_comb begin
      next_bin        = wr_en_out ? (b_count_ptr + PTR_W'(1)) : b_count_ptr;
      next_gray       = next_bin ^ (next_bin >> 1);
      used_nxt        = next_bin - rd_bin;
      free_nxt        = PTR_W'(DEPTH) - used_nxt;
      full_nxt        = (used_nxt == PTR_W'(DEPTH));
      almost_full_nxt = (32'(free_nxt) <= 32'(af_margin)) | full_nxt;
   end

   // State and registered outputs; reset beats clear beats write
   always_ff @(posedge b_ctr_clk) begin
      if (b_ctr_reset) begin
         b_count_ptr     <= '0;
         g_count_ptr     <= '0;
         full_out        <= 1'b0;
         almost_full_out <= 1'b0;
         wr_ack_out      <= 1'b0;
         overflow_out    <= 1'b0;
      end else if (b_ctr_clear) begin
         b_count_ptr     <= '0;
         g_count_ptr     <= '0;
         full_out        <= 1'b0;
         almost_full_out <= 1'b0;
         wr_ack_out      <= 1'b0;
         overflow_out    <= 1'b0;
      end else begin
         b_count_ptr     <= next_bin;
         g_count_ptr     <= next_gray;
         full_out        <= full_nxt;
         almost_full_out <= almost_full_nxt;
         wr_ack_out      <= wr_en_out;
         overflow_out    <= b_ctr_enable_in & full_out;
      end
   end

endmodule

// File: tb/tb_write_ptr_counter.sv
// -----------------------------------------------------------------------------
// tb_write_ptr_counter
// Self-checking bench for write_ptr_counter (a_length=3, af_margin=1).
// The reference keeps absolute write/read counts as integers; pointers,
// occupancy and flags are derived from them with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_write_ptr_counter;

   localparam int unsigned AL    = 3;
   localparam int unsigned AFM   = 1;
   localparam int          DEPTH = 8;
   localparam int          MOD   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          clr;
   logic [AL:0]   rd_gray;
   logic [AL:0]   b_ptr;
   logic [AL:0]   g_ptr;
   logic [AL-1:0] waddr;
   logic          wr_en;
   logic          full;
   logic          afull;
   logic          ack;
   logic          ovf;

   int checks = 0;
   int errors = 0;

   // reference state: absolute counts since last reset/clear
   int m_w = 0;
   int m_r = 0;
   logic m_full = 1'b0;
   logic m_af   = 1'b0;
   logic m_ack  = 1'b0;
   logic m_ovf  = 1'b0;
   int ack_count = 0;

   write_ptr_counter #(.a_length(AL), .af_margin(AFM)) dut (
      .b_ctr_clk           (clk),
      .b_ctr_reset         (rst),
      .b_ctr_enable_in     (en),
      .b_ctr_clear         (clr),
      .rd_gray_ptr_sync_in (rd_gray),
      .b_count_ptr         (b_ptr),
      .g_count_ptr         (g_ptr),
      .wr_addr             (waddr),
      .wr_en_out           (wr_en),
      .full_out            (full),
      .almost_full_out     (afull),
      .wr_ack_out          (ack),
      .overflow_out        (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [AL:0] gray_of(input int v);
      logic [AL:0] b;
      b = (AL+1)'(v % MOD);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check combinational outputs, clock, check registers
   task automatic step(input logic e, input logic c, input logic r_s, input int r,
                       input bit chk_comb);
      int used;
      en      = e;
      clr     = c;
      rst     = r_s;
      rd_gray = gray_of(r);
      #1;
      if (chk_comb) begin
         chk("wr_en", 32'(wr_en), 32'(e & ~m_full));
         chk("wr_addr", 32'(waddr), 32'(m_w % DEPTH));
      end
      if (r_s || c) begin
         m_w = 0; m_r = 0;
         m_full = 1'b0; m_af = 1'b0; m_ack = 1'b0; m_ovf = 1'b0;
      end else begin
         m_r   = r;
         m_ack = e & ~m_full;
         m_ovf = e & m_full;
         if (m_ack) m_w++;
         used   = m_w - m_r;
         m_full = (used == DEPTH);
         m_af   = ((DEPTH - used) <= int'(AFM));
      end
      @(posedge clk);
      #1;
      if (ack === 1'b1) ack_count++;
      chk("b_count_ptr", 32'(b_ptr), 32'(m_w % MOD));
      chk("g_count_ptr", 32'(g_ptr), 32'(gray_of(m_w)));
      chk("full", 32'(full), 32'(m_full));
      chk("almost_full", 32'(afull), 32'(m_af));
      chk("wr_ack", 32'(ack), 32'(m_ack));
      chk("overflow", 32'(ovf), 32'(m_ovf));
   endtask

   initial begin
      logic [AL:0] prev_g;
      int r_next;
      bit e, c, rs;

      rst = 1'b1; en = 1'b1; clr = 1'b0; rd_gray = '0;

      // reset held for two edges with a pending request
      step(1'b1, 1'b0, 1'b1, 0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 0, 1'b1);
      en = 1'b1; rst = 1'b0; #1;
      chk("wren_after_reset", 32'(wr_en), 32'd1);

      // fill from empty with the read pointer at zero
      ack_count = 0;
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b1);
      chk("fill7_b", 32'(b_ptr), 32'b0111);
      chk("fill7_g", 32'(g_ptr), 32'b0100);
      chk("fill7_af", 32'(afull), 32'd1);
      chk("fill7_full", 32'(full), 32'd0);
      step(1'b1, 1'b0, 1'b0, 0, 1'b1);
      chk("fill8_b", 32'(b_ptr), 32'b1000);
      chk("fill8_g", 32'(g_ptr), 32'b1100);
      chk("fill8_full", 32'(full), 32'd1);
      chk("fill8_acks", 32'(ack_count), 32'd8);

      // overflow: three requests while full
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 0, 1'b1);
         chk("ovf_b_hold", 32'(b_ptr), 32'b1000);
      end

      // read advances together with a request that is still rejected
      step(1'b1, 1'b0, 1'b0, 1, 1'b1);
      chk("drain_ovf", 32'(ovf), 32'd1);
      chk("drain_full", 32'(full), 32'd0);
      chk("drain_af", 32'(afull), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1, 1'b1);
      chk("drain_b", 32'(b_ptr), 32'b1001);
      chk("drain_full2", 32'(full), 32'd1);

      // wrap: read pointer tracks the write pointer, 16 writes
      step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      prev_g = g_ptr;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b0, m_w, 1'b1);
         chk("wrap_gray_1bit", 32'($countones(prev_g ^ g_ptr)), 32'd1);
         chk("wrap_not_full", 32'(full), 32'd0);
         if (i == 14) begin
            chk("wrap_b15", 32'(b_ptr), 32'b1111);
            chk("wrap_g15", 32'(g_ptr), 32'b1000);
         end
         prev_g = g_ptr;
      end
      chk("wrap_b0", 32'(b_ptr), 32'b0000);
      chk("wrap_g0", 32'(g_ptr), 32'b0000);

      // clear mid-operation after five writes
      step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);
      chk("clear_b", 32'(b_ptr), 32'd0);
      chk("clear_ack", 32'(ack), 32'd0);

      // randomized traffic with legal read-pointer movement
      for (int i = 0; i < 400; i++) begin
         e  = ($urandom_range(0, 3) != 0);
         c  = ($urandom_range(0, 39) == 0);
         rs = ($urandom_range(0, 79) == 0);
         if (c || rs) begin
            r_next = 0;
         end else begin
            if (m_w - m_r > 0 && $urandom_range(0, 2) == 0)
               r_next = m_r + int'($urandom_range(0, 32'(m_w - m_r)));
            else
               r_next = m_r;
         end
         step(e, c, rs, r_next, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
